// File: rtl/serial_adder.sv
// Bit-serial (BPC bits per cycle) adder/subtractor with start/busy/done handshake.
// Subtraction is done as a + ~b + 1, so cout=1 means "no borrow".
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] areg, breg, sreg;
  logic             carry, cout_r, ovf_r;
  logic [BPC-1:0]   a_sl, b_sl, s_sl;
  logic             c_sl, msb_cin, last, accept;

  assign last   = (k == CW'(STEPS - 1));
  assign accept = start && (state != RUN);

  // Carry into the slice MSB is recovered from its sum bit and operand bits.
  always_comb begin
    a_sl            = areg[k*BPC +: BPC];
    b_sl            = breg[k*BPC +: BPC];
    {c_sl, s_sl}    = {1'b0, a_sl} + {1'b0, b_sl} + {{BPC{1'b0}}, carry};
    msb_cin         = s_sl[BPC-1] ^ a_sl[BPC-1] ^ b_sl[BPC-1];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      areg   <= '0;
      breg   <= '0;
      sreg   <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      areg  <= a;
      breg  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
    end else if (state == RUN) begin
      sreg[k*BPC +: BPC] <= s_sl;
      carry              <= c_sl;
      if (last) begin
        cout_r <= c_sl;
        ovf_r  <= msb_cin ^ c_sl;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sreg;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: three serial_adder instances (WIDTH=8, BPC=1/4/8) driven in turn;
// a negedge monitor pops expected results and checks value, latency and busy length.
module tb_serial_adder;

  localparam int NI = 3;
  localparam int ST[NI] = '{8, 2, 1};

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v[NI];
  logic       sub_v[NI];
  logic [7:0] a_v[NI];
  logic [7:0] b_v[NI];
  logic       cin_v[NI];
  logic       busy_v[NI];
  logic       done_v[NI];
  logic [7:0] sum_v[NI];
  logic       cout_v[NI];
  logic       ovf_v[NI];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq[NI][$];
  exp_t last_e[NI];
  bit   has_last[NI];

  serial_adder #(.WIDTH(8), .BPC(1)) u_b1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0]), .b(b_v[0]),
    .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
    .cout(cout_v[0]), .ovf(ovf_v[0]));

  serial_adder #(.WIDTH(8), .BPC(4)) u_b4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
    .cout(cout_v[1]), .ovf(ovf_v[1]));

  serial_adder #(.WIDTH(8), .BPC(8)) u_b8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
    .cout(cout_v[2]), .ovf(ovf_v[2]));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, required %0h (cycle %0d)", name, i, act, req, cyc);
    end
  endtask

  // Reference arithmetic: returns {ovf, cout, sum}.
  function automatic logic [9:0] ref_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                                        input logic ci);
    logic [8:0] r;
    logic [7:0] d;
    if (s) begin
      d = av - bv;
      return {(av[7] != bv[7]) && (d[7] != av[7]), (av >= bv), d};
    end
    r = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
    return {(av[7] == bv[7]) && (r[7] != av[7]), r[8], r[7:0]};
  endfunction

  // Called at posedge+#1; start is sampled on the next rising edge.
  task automatic issue(input int i, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic [7:0] es, input logic eco, input logic eov);
    exp_t e;
    e.s = es; e.co = eco; e.ov = eov; e.cyc = cyc + 1 + ST[i];
    sbq[i].push_back(e);
    sub_v[i] = s; a_v[i] = av; b_v[i] = bv; cin_v[i] = ci; start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    sub_v[i] = ~s; a_v[i] = 8'($urandom); b_v[i] = 8'($urandom); cin_v[i] = ~ci;
  endtask

  task automatic issue_ref(input int i, input logic s, input logic [7:0] av, input logic [7:0] bv,
                           input logic ci);
    logic [9:0] r;
    r = ref_op(s, av, bv, ci);
    issue(i, s, av, bv, ci, r[7:0], r[8], r[9]);
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(posedge clk); #1;
      if (sbq[i].size() == 0 && !busy_v[i] && !done_v[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout inst%0d: pending=%0d, required 0 within 64 cycles", i, sbq[i].size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      sbq[i].delete();
      last_e[i] = '{s: 8'h00, co: 1'b0, ov: 1'b0, cyc: 0};
      has_last[i] = 1'b1;
    end
    rst = 1'b0;
  endtask

  // Monitor
  initial begin
    int busy_cnt[NI];
    exp_t e;
    for (int i = 0; i < NI; i++) busy_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          busy_cnt[i] = 0;
        end else if (done_v[i]) begin
          if (sbq[i].size() == 0) begin
            chk("unexpected_done", i, 32'(done_v[i]), 32'd0);
          end else begin
            e = sbq[i].pop_front();
            chk("sum", i, 32'(sum_v[i]), 32'(e.s));
            chk("cout", i, 32'(cout_v[i]), 32'(e.co));
            chk("ovf", i, 32'(ovf_v[i]), 32'(e.ov));
            chk("done_cycle", i, 32'(cyc), 32'(e.cyc));
            chk("busy_len", i, 32'(busy_cnt[i]), 32'(ST[i]));
            chk("busy_in_done", i, 32'(busy_v[i]), 32'd0);
            last_e[i] = e;
            has_last[i] = 1'b1;
          end
          busy_cnt[i] = 0;
        end else if (busy_v[i]) begin
          busy_cnt[i]++;
        end else if (has_last[i]) begin
          chk("hold", i, {22'd0, ovf_v[i], cout_v[i], sum_v[i]},
              {22'd0, last_e[i].ov, last_e[i].co, last_e[i].s});
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] ra, rb;
    logic       rs, rc;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; sub_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0;
      has_last[i] = 1'b0;
    end
    #1;
    do_reset();
    @(posedge clk); #1;

    for (int i = 0; i < NI; i++) begin
      issue(i, 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0); wait_idle(i);
      issue(i, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); wait_idle(i);
      issue(i, 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1); wait_idle(i);
      issue(i, 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0); wait_idle(i);
      issue(i, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1); wait_idle(i);
      issue(i, 1'b1, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0); wait_idle(i);
      issue(i, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1); wait_idle(i);
      // back-to-back: second start sampled on the edge after DONE is entered
      issue(i, 1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
      repeat (ST[i]) begin @(posedge clk); #1; end
      issue(i, 1'b1, 8'h34, 8'h12, 1'b0, 8'h22, 1'b1, 1'b0);
      wait_idle(i);
    end

    // start pulsed mid-RUN must be ignored
    issue(0, 1'b0, 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    sub_v[0] = 1'b1; a_v[0] = 8'hAA; b_v[0] = 8'h55; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_idle(0);

    // reset mid-RUN aborts with no done; then a fresh op completes
    issue(0, 1'b0, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    do_reset();
    repeat (3) begin @(posedge clk); #1; end
    issue(0, 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    wait_idle(0);

    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 300; n++) begin
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
        issue_ref(i, rs, ra, rb, rc);
        wait_idle(i);
      end
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
